keypad_scan: RTL and testbench



---
 rtl/keypad_pkg.sv | 46 ++++
 rtl/keypad_debounce.sv | 107 ++++++++++
 rtl/keypad_scan.sv | 111 +++++++++++
 tb/tb_keypad_scan.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and the key-position to code table for the keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DEBOUNCE,
    ST_PRESSED,
    ST_RELEASE
  } state_t;

  typedef enum logic [1:0] {
    FC_NONE,
    FC_SINGLE,
    FC_MULTI
  } frame_class_t;

  // Matrix positions (row*4 + col) of the two control keys.
  localparam logic [3:0] KEY_STAR = 4'd12;
  localparam logic [3:0] KEY_HASH = 4'd14;

  function automatic logic [3:0] key_lookup(input logic [3:0] idx);
    logic [3:0] code;
    code = 4'h0;
    case (idx)
      4'd0:  code = 4'h1;
      4'd1:  code = 4'h2;
      4'd2:  code = 4'h3;
      4'd3:  code = 4'hA;
      4'd4:  code = 4'h4;
      4'd5:  code = 4'h5;
      4'd6:  code = 4'h6;
      4'd7:  code = 4'hB;
      4'd8:  code = 4'h7;
      4'd9:  code = 4'h8;
      4'd10: code = 4'h9;
      4'd11: code = 4'hC;
      4'd12: code = 4'hE;
      4'd13: code = 4'h0;
      4'd14: code = 4'hF;
      4'd15: code = 4'hD;
      default: code = 4'h0;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Frame-rate press/release debouncer; emits one strobe per accepted key press.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CNT = 3
) (
  input  logic         i_clk,
  input  logic         i_rstn,
  input  logic         i_frame_done,
  input  frame_class_t i_class,
  input  logic [3:0]   i_key_idx,
  output logic [3:0]   o_key_code,
  output logic         o_key_valid,
  output logic         o_key_clear,
  output logic         o_key_enter
);

  localparam int CNT_W = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_count;
  logic [3:0]       r_cand;
  logic [3:0]       r_key_code;
  logic             r_key_valid;
  logic             r_key_clear;
  logic             r_key_enter;

  logic w_single;
  assign w_single = (i_class == FC_SINGLE);

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_state     <= ST_IDLE;
      r_count     <= '0;
      r_cand      <= '0;
      r_key_code  <= 4'h0;
      r_key_valid <= 1'b0;
      r_key_clear <= 1'b0;
      r_key_enter <= 1'b0;
    end else begin
      r_key_valid <= 1'b0;
      r_key_clear <= 1'b0;
      r_key_enter <= 1'b0;
      if (i_frame_done) begin
        case (r_state)
          ST_IDLE: begin
            if (w_single) begin
              r_cand  <= i_key_idx;
              r_count <= CNT_W'(1);
              r_state <= ST_DEBOUNCE;
            end
          end
          ST_DEBOUNCE: begin
            // A different key aborts the run; it must start again from IDLE.
            if (w_single && (i_key_idx == r_cand)) begin
              if (r_count == CNT_LAST) begin
                r_count <= '0;
                r_state <= ST_PRESSED;
                if (r_cand == KEY_STAR) begin
                  r_key_clear <= 1'b1;
                end else if (r_cand == KEY_HASH) begin
                  r_key_enter <= 1'b1;
                end else begin
                  r_key_valid <= 1'b1;
                  r_key_code  <= key_lookup(r_cand);
                end
              end else begin
                r_count <= r_count + CNT_W'(1);
              end
            end else begin
              r_count <= '0;
              r_state <= ST_IDLE;
            end
          end
          ST_PRESSED: begin
            if (!w_single) begin
              r_count <= CNT_W'(1);
              r_state <= ST_RELEASE;
            end
          end
          ST_RELEASE: begin
            if (w_single) begin
              r_count <= '0;
              r_state <= ST_PRESSED;
            end else if (r_count == CNT_LAST) begin
              r_count <= '0;
              r_state <= ST_IDLE;
            end else begin
              r_count <= r_count + CNT_W'(1);
            end
          end
          default: begin
            r_count <= '0;
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign o_key_code  = r_key_code;
  assign o_key_valid = r_key_valid;
  assign o_key_clear = r_key_clear;
  assign o_key_enter = r_key_enter;

endmodule

// File: rtl/keypad_scan.sv
// 4x4 active-low keypad scanner: row synchroniser, column scan, frame map and
// classification feeding the frame-rate debouncer.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 4,
  parameter int DEBOUNCE_CNT = 3
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic [3:0] i_row_in,
  output logic [3:0] o_col_out,
  output logic [3:0] o_key_code,
  output logic       o_key_valid,
  output logic       o_key_clear,
  output logic       o_key_enter
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  logic [3:0]       r_row_meta;
  logic [3:0]       r_row_sync;
  logic [DIV_W-1:0] r_div;
  logic [1:0]       r_col;
  logic [15:0]      r_map;
  frame_class_t     r_class;
  logic [3:0]       r_key_idx;
  logic             r_frame_done;

  logic        w_slot_end;
  logic        w_frame_end;
  logic [15:0] w_map_next;
  logic [4:0]  w_low_cnt;
  logic [3:0]  w_low_idx;

  assign w_slot_end  = (r_div == DIV_LAST);
  assign w_frame_end = w_slot_end && (r_col == 2'd3);
  assign o_col_out   = ~(4'b0001 << r_col);

  // Map bit index is row*4 + col; the current column is merged in on its
  // last slot cycle so the frame-end classification sees the whole frame.
  always_comb begin
    w_map_next = r_map;
    if (w_slot_end) begin
      for (int r = 0; r < 4; r++) begin
        w_map_next[{2'(r), r_col}] = r_row_sync[r];
      end
    end
  end

  always_comb begin
    w_low_cnt = 5'd0;
    w_low_idx = 4'd0;
    for (int k = 0; k < 16; k++) begin
      if (!w_map_next[k]) begin
        w_low_cnt = w_low_cnt + 5'd1;
        w_low_idx = 4'(k);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_row_meta   <= 4'hF;
      r_row_sync   <= 4'hF;
      r_div        <= '0;
      r_col        <= 2'd0;
      r_map        <= 16'hFFFF;
      r_class      <= FC_NONE;
      r_key_idx    <= 4'd0;
      r_frame_done <= 1'b0;
    end else begin
      r_row_meta   <= i_row_in;
      r_row_sync   <= r_row_meta;
      r_map        <= w_map_next;
      r_frame_done <= w_frame_end;
      if (w_slot_end) begin
        r_div <= '0;
        r_col <= r_col + 2'd1;
      end else begin
        r_div <= r_div + DIV_W'(1);
      end
      if (w_frame_end) begin
        r_key_idx <= w_low_idx;
        if (w_low_cnt == 5'd0) begin
          r_class <= FC_NONE;
        end else if (w_low_cnt == 5'd1) begin
          r_class <= FC_SINGLE;
        end else begin
          r_class <= FC_MULTI;
        end
      end
    end
  end

  keypad_debounce #(
    .DEBOUNCE_CNT(DEBOUNCE_CNT)
  ) u_debounce (
    .i_clk       (i_clk),
    .i_rstn      (i_rstn),
    .i_frame_done(r_frame_done),
    .i_class     (r_class),
    .i_key_idx   (r_key_idx),
    .o_key_code  (o_key_code),
    .o_key_valid (o_key_valid),
    .o_key_clear (o_key_clear),
    .o_key_enter (o_key_enter)
  );

endmodule

// File: tb/tb_keypad_scan.sv
// Self-checking bench for keypad_scan: models a passive key matrix and predicts
// strobes from frame-level press/release run lengths.
module tb_keypad_scan;

  localparam int SCAN_DIV     = 4;
  localparam int DEBOUNCE_CNT = 3;
  localparam int FRAME_CYC    = 4 * SCAN_DIV;

  logic       clk  = 1'b0;
  logic       rstn = 1'b0;
  logic [3:0] rowIn;
  logic [3:0] colOut;
  logic [3:0] keyCode;
  logic       keyValid;
  logic       keyClear;
  logic       keyEnter;

  // Bit row*4+col set means that key is physically held down.
  logic [15:0] tbKeys = 16'h0;
  string       layout = "123A456B789C*0#D";

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  bit         armed;
  int         runKey, runLen, quietLen;
  int         pendCycle, pendKind;
  logic [3:0] pendCode;
  logic [3:0] expCode;

  int obsValidCnt = 0, obsClearCnt = 0, obsEnterCnt = 0;
  int lastValidCyc = 0;

  keypad_scan #(
    .SCAN_DIV    (SCAN_DIV),
    .DEBOUNCE_CNT(DEBOUNCE_CNT)
  ) dut (
    .i_clk      (clk),
    .i_rstn     (rstn),
    .i_row_in   (rowIn),
    .o_col_out  (colOut),
    .o_key_code (keyCode),
    .o_key_valid(keyValid),
    .o_key_clear(keyClear),
    .o_key_enter(keyEnter)
  );

  always #5 clk = ~clk;

  // A held key shorts its row to the driven (low) column.
  always_comb begin
    rowIn = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (tbKeys[4'(r * 4 + c)] && !colOut[c]) rowIn[r] = 1'b0;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      if (errors <= 30)
        $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, observed, expected);
    end
  endtask

  function automatic logic [15:0] keyMask(input byte ch);
    logic [15:0] m;
    m = 16'h0;
    for (int i = 0; i < 16; i++) begin
      if (layout[i] == ch) m = 16'h1 << i;
    end
    return m;
  endfunction

  task automatic modelReset();
    armed     = 1'b1;
    runKey    = 0;
    runLen    = 0;
    quietLen  = 0;
    pendCycle = -1;
    pendKind  = 0;
    pendCode  = 4'h0;
    expCode   = 4'h0;
  endtask

  task automatic accept(input int k);
    byte ch;
    ch = layout[k];
    pendCycle = cyc + 2;
    if (ch == "*") begin
      pendKind = 1;
    end else if (ch == "#") begin
      pendKind = 2;
    end else begin
      pendKind = 0;
      if (ch >= "0" && ch <= "9") pendCode = 4'(ch - "0");
      else pendCode = 4'(ch - "A" + 10);
    end
  endtask

  // A press is accepted after DEBOUNCE_CNT consecutive frames with the same lone
  // key; the next press needs DEBOUNCE_CNT consecutive frames without a lone key.
  task automatic modelFrame();
    int  n;
    int  k;
    bit  single;
    n = 0;
    k = 0;
    for (int i = 0; i < 16; i++) begin
      if (tbKeys[i]) begin
        n++;
        k = i;
      end
    end
    single = (n == 1);
    if (armed) begin
      if (!single) runLen = 0;
      else if (runLen == 0) begin
        runKey = k;
        runLen = 1;
      end else if (k == runKey) runLen++;
      else runLen = 0;
      if (runLen == DEBOUNCE_CNT) begin
        accept(runKey);
        armed    = 1'b0;
        runLen   = 0;
        quietLen = 0;
      end
    end else begin
      if (single) quietLen = 0;
      else quietLen++;
      if (quietLen == DEBOUNCE_CNT) begin
        armed    = 1'b1;
        quietLen = 0;
      end
    end
  endtask

  task automatic runCycle();
    logic expV, expC, expE;
    logic [3:0] expCol;
    @(negedge clk);
    if (!rstn) begin
      cyc = 0;
      modelReset();
    end else begin
      cyc++;
    end
    expV = 1'b0;
    expC = 1'b0;
    expE = 1'b0;
    if (cyc == pendCycle) begin
      case (pendKind)
        1: expC = 1'b1;
        2: expE = 1'b1;
        default: begin
          expV    = 1'b1;
          expCode = pendCode;
        end
      endcase
      pendCycle = -1;
    end
    expCol = 4'hF ^ (4'b0001 << ((cyc / SCAN_DIV) % 4));
    checkOutput("col_out", 16'(colOut), 16'(expCol));
    checkOutput("key_valid", 16'(keyValid), 16'(expV));
    checkOutput("key_clear", 16'(keyClear), 16'(expC));
    checkOutput("key_enter", 16'(keyEnter), 16'(expE));
    checkOutput("key_code", 16'(keyCode), 16'(expCode));
    if (keyValid) begin
      obsValidCnt++;
      lastValidCyc = cyc;
    end
    if (keyClear) obsClearCnt++;
    if (keyEnter) obsEnterCnt++;
    if (rstn && (cyc % FRAME_CYC == FRAME_CYC - 1)) modelFrame();
  endtask

  // Called at a frame end; holds keys for whole frames.
  task automatic applyStimulus(input logic [15:0] keys, input int frames);
    tbKeys = keys;
    repeat (frames * FRAME_CYC) runCycle();
  endtask

  // Leaves the bench at the end of the first post-reset frame.
  task automatic applyReset(input int nCycles);
    rstn = 1'b0;
    runCycle();
    checkOutput("rst_col_out", 16'(colOut), 16'h000E);
    checkOutput("rst_key_code", 16'(keyCode), 16'h0000);
    checkOutput("rst_strobes", 16'({keyValid, keyClear, keyEnter}), 16'h0000);
    repeat (nCycles - 1) runCycle();
    rstn = 1'b1;
    repeat (FRAME_CYC - 1) runCycle();
  endtask

  task automatic resetMidFrame(input int offset);
    repeat (offset) runCycle();
    applyReset(1);
  endtask

  initial begin
    int v0, c0, e0, startCyc, sel;
    logic [15:0] keys;
    modelReset();
    $display("[TB] start");

    applyReset(3);
    applyStimulus(16'h0, 5);
    checkOutput("s1_no_strobes", 16'(obsValidCnt + obsClearCnt + obsEnterCnt), 16'd0);

    v0 = obsValidCnt;
    startCyc = cyc + 1;
    applyStimulus(keyMask("5"), 10);
    applyStimulus(16'h0, 4);
    checkOutput("s2_valid_count", 16'(obsValidCnt - v0), 16'd1);
    checkOutput("s2_timing", 16'(lastValidCyc - startCyc), 16'd49);
    checkOutput("s2_code", 16'(keyCode), 16'h5);

    v0 = obsValidCnt;
    applyStimulus(keyMask("9"), 2);
    applyStimulus(16'h0, 1);
    startCyc = cyc + 1;
    applyStimulus(keyMask("9"), 4);
    applyStimulus(16'h0, 4);
    checkOutput("s3_valid_count", 16'(obsValidCnt - v0), 16'd1);
    checkOutput("s3_timing", 16'(lastValidCyc - startCyc), 16'd49);
    checkOutput("s3_code", 16'(keyCode), 16'h9);

    v0 = obsValidCnt;
    c0 = obsClearCnt;
    e0 = obsEnterCnt;
    applyStimulus(keyMask("*"), 4);
    applyStimulus(16'h0, 3);
    checkOutput("s4_clear_count", 16'(obsClearCnt - c0), 16'd1);
    checkOutput("s4_code_kept", 16'(keyCode), 16'h9);
    applyStimulus(keyMask("#"), 4);
    applyStimulus(16'h0, 4);
    checkOutput("s4_enter_count", 16'(obsEnterCnt - e0), 16'd1);
    checkOutput("s4_valid_count", 16'(obsValidCnt - v0), 16'd0);

    v0 = obsValidCnt;
    applyStimulus(keyMask("1"), 5);
    applyStimulus(keyMask("1") | keyMask("D"), 2);
    applyStimulus(keyMask("D"), 5);
    checkOutput("s5_rollover_count", 16'(obsValidCnt - v0), 16'd1);
    checkOutput("s5_rollover_code", 16'(keyCode), 16'h1);
    applyStimulus(16'h0, 3);
    applyStimulus(keyMask("D"), 3);
    applyStimulus(16'h0, 4);
    checkOutput("s5_repress_count", 16'(obsValidCnt - v0), 16'd2);
    checkOutput("s5_repress_code", 16'(keyCode), 16'hD);

    v0 = obsValidCnt;
    applyStimulus(keyMask("7"), 2);
    tbKeys = keyMask("7");
    resetMidFrame(5);
    checkOutput("s6_no_strobe", 16'(obsValidCnt - v0), 16'd0);
    checkOutput("s6_code_reset", 16'(keyCode), 16'h0);
    applyStimulus(keyMask("7"), 3);
    applyStimulus(16'h0, 4);
    checkOutput("s6_valid_count", 16'(obsValidCnt - v0), 16'd1);
    checkOutput("s6_code", 16'(keyCode), 16'h7);

    for (int s = 0; s < 60; s++) begin
      sel = $urandom_range(0, 9);
      if (sel < 3) keys = 16'h0;
      else if (sel < 5) keys = keyMask("5");
      else if (sel < 6) keys = keyMask("*");
      else if (sel < 7) keys = keyMask("#");
      else if (sel < 9) keys = 16'h1 << $urandom_range(0, 15);
      else keys = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
      applyStimulus(keys, $urandom_range(1, 5));
      if ($urandom_range(0, 9) == 0) resetMidFrame($urandom_range(0, 14));
    end
    applyStimulus(16'h0, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
